intu_writeback_queue: RTL and testbench

Buffers completed INTU cluster results and hands them to the register-file writeback port one warp-packet per handshake. It sits directly downstream of the INTU cluster, which has no backpressure. The queue therefore absorbs writeback-port stalls, tells the issue logic when to stop issuing INT instructions, and flags any result that is lost.

---
 rtl/intu_writeback_queue_pkg.sv | 40 ++++
 rtl/intu_writeback_queue_if.sv | 33 +++
 rtl/wb_sync_fifo.sv | 59 +++++
 rtl/intu_writeback_queue.sv | 97 +++++++++
 tb/tb_intu_writeback_queue.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/intu_writeback_queue_pkg.sv
// rtl/intu_writeback_queue_pkg.sv - INTU writeback queue parameters, lane field map and entry type
package intu_writeback_queue_pkg;

    localparam int SIZE_CORE      = 32;
    localparam int SIZE_DATA      = 32;
    localparam int SIZE_REGFILE   = 6;
    localparam int NUM_WARP_LOG   = 3;
    localparam int INST_TYPES_LOG = 3;

    localparam int INTU_LANE_W    = SIZE_DATA + SIZE_REGFILE + 1 + INST_TYPES_LOG;

    // Lane packet fields, MSB down: data, dest reg, write-enable, inst type
    localparam int LANE_INST_LSB  = 0;
    localparam int LANE_WE_BIT    = INST_TYPES_LOG;
    localparam int LANE_DEST_LSB  = LANE_WE_BIT + 1;
    localparam int LANE_DEST_MSB  = LANE_DEST_LSB + SIZE_REGFILE - 1;
    localparam int LANE_DATA_LSB  = LANE_DEST_MSB + 1;
    localparam int LANE_DATA_MSB  = LANE_DATA_LSB + SIZE_DATA - 1;

    localparam int INTU_WB_DEPTH  = 4;

    typedef struct packed {
        logic [NUM_WARP_LOG-1:0]        warp;
        logic [SIZE_CORE-1:0]           mask;
        logic [SIZE_REGFILE-1:0]        destReg;
        logic [SIZE_CORE*SIZE_DATA-1:0] data;
    } wbEntry_t;

    localparam int WB_ENTRY_W = $bits(wbEntry_t);

    function automatic logic [$clog2(SIZE_CORE)-1:0] lowestSetLane(input logic [SIZE_CORE-1:0] m);
        logic [$clog2(SIZE_CORE)-1:0] idx;
        idx = '0;
        for (int k = SIZE_CORE - 1; k >= 0; k--) begin
            if (m[k]) idx = k[$clog2(SIZE_CORE)-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/intu_writeback_queue_if.sv
// rtl/intu_writeback_queue_if.sv - INTU result input and register-file writeback port bundle
interface intu_writeback_queue_if
    import intu_writeback_queue_pkg::*;
#(
    parameter int DEPTH = INTU_WB_DEPTH
);
    logic [NUM_WARP_LOG-1:0]          intuWarp_i;
    logic                             intuPacketValid_i;
    logic [SIZE_CORE-1:0]             intuMask_i;
    logic [SIZE_CORE*INTU_LANE_W-1:0] intuPacketLanes_i;
    logic                             wbReady_o;
    logic                             wbValid_o;
    logic [NUM_WARP_LOG-1:0]          wbWarp_o;
    logic [SIZE_CORE-1:0]             wbMask_o;
    logic [SIZE_REGFILE-1:0]          wbDestReg_o;
    logic [SIZE_CORE*SIZE_DATA-1:0]   wbData_o;
    logic                             wbReady_i;
    logic                             overflow_o;
    logic [$clog2(DEPTH):0]           fifoCount_o;

    modport slave (
        input  intuWarp_i, intuPacketValid_i, intuMask_i, intuPacketLanes_i, wbReady_i,
        output wbReady_o, wbValid_o, wbWarp_o, wbMask_o, wbDestReg_o, wbData_o,
               overflow_o, fifoCount_o
    );

    modport master (
        output intuWarp_i, intuPacketValid_i, intuMask_i, intuPacketLanes_i, wbReady_i,
        input  wbReady_o, wbValid_o, wbWarp_o, wbMask_o, wbDestReg_o, wbData_o,
               overflow_o, fifoCount_o
    );

endinterface

// File: rtl/wb_sync_fifo.sv
// rtl/wb_sync_fifo.sv - synchronous FIFO with a registered head entry that holds its value when empty
module wb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         headData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] nextRd;
    logic [CNT_W-1:0] countReg;
    logic [WIDTH-1:0] headReg;

    assign nextRd   = rdPtr + PTR_W'(1);
    assign full     = (countReg == CNT_W'(DEPTH));
    assign empty    = (countReg == '0);
    assign count    = countReg;
    assign headData = headReg;

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushData;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            countReg <= '0;
            headReg  <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= nextRd;
            case ({push, pop})
                2'b10:   countReg <= countReg + CNT_W'(1);
                2'b01:   countReg <= countReg - CNT_W'(1);
                default: countReg <= countReg;
            endcase
            // Head is a copy of mem[rdPtr]; it is left alone on the last pop so outputs hold
            if (push && (empty || (pop && countReg == CNT_W'(1)))) begin
                headReg <= pushData;
            end else if (pop && countReg > CNT_W'(1)) begin
                headReg <= mem[nextRd];
            end
        end
    end

endmodule

// File: rtl/intu_writeback_queue.sv
// rtl/intu_writeback_queue.sv - buffers INTU cluster results for the register-file writeback port
// Optional same-cycle bypass when empty: define INTU_WB_BYPASS_EN
module intu_writeback_queue
    import intu_writeback_queue_pkg::*;
#(
    parameter int DEPTH = INTU_WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    intu_writeback_queue_if.slave  wb
);
    logic [SIZE_CORE-1:0]          effMask;
    logic [INTU_LANE_W-1:0]        lane;
    logic [$clog2(SIZE_CORE)-1:0]  destLane;
    logic                          unusedInstType;
    wbEntry_t                      inEntry;
    wbEntry_t                      headEntry;
    wbEntry_t                      outEntry;
    logic                          pushable;
    logic                          bypass;
    logic                          fifoPush;
    logic                          fifoPop;
    logic                          fifoFull;
    logic                          fifoEmpty;
    logic                          outValid;
    logic                          overflowReg;
    logic [$clog2(DEPTH):0]        fifoCount;

    assign destLane = lowestSetLane(effMask);

    always_comb begin
        effMask        = '0;
        inEntry        = '0;
        lane           = '0;
        unusedInstType = 1'b0;
        for (int k = 0; k < SIZE_CORE; k++) begin
            lane       = wb.intuPacketLanes_i[k*INTU_LANE_W +: INTU_LANE_W];
            effMask[k] = wb.intuMask_i[k] & lane[LANE_WE_BIT];
            if (effMask[k]) begin
                inEntry.data[k*SIZE_DATA +: SIZE_DATA] = lane[LANE_DATA_MSB:LANE_DATA_LSB];
            end
            unusedInstType = unusedInstType ^ (^lane[LANE_WE_BIT-1:LANE_INST_LSB]);
        end
        inEntry.warp    = wb.intuWarp_i;
        inEntry.mask    = effMask;
        // All active lanes carry the same dest, so the lowest active lane is representative
        inEntry.destReg = wb.intuPacketLanes_i[int'(destLane)*INTU_LANE_W + LANE_DEST_LSB +: SIZE_REGFILE];
    end

    assign pushable = wb.intuPacketValid_i & (|effMask);
    assign fifoPop  = ~fifoEmpty & wb.wbReady_i;

`ifdef INTU_WB_BYPASS_EN
    assign bypass   = fifoEmpty & wb.wbReady_i & pushable;
    assign outValid = bypass | ~fifoEmpty;
    assign outEntry = bypass ? inEntry : headEntry;
`else
    assign bypass   = 1'b0;
    assign outValid = ~fifoEmpty;
    assign outEntry = headEntry;
`endif

    assign fifoPush = pushable & (~fifoFull | fifoPop) & ~bypass;

    wb_sync_fifo #(
        .WIDTH (WB_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifoPush),
        .pushData (inEntry),
        .pop      (fifoPop),
        .headData (headEntry),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflowReg <= 1'b0;
        end else if (pushable && fifoFull && !fifoPop) begin
            overflowReg <= 1'b1;
        end
    end

    assign wb.wbReady_o   = ~fifoFull;
    assign wb.wbValid_o   = outValid;
    assign wb.wbWarp_o    = outEntry.warp;
    assign wb.wbMask_o    = outValid ? outEntry.mask : '0;
    assign wb.wbDestReg_o = outEntry.destReg;
    assign wb.wbData_o    = outEntry.data;
    assign wb.overflow_o  = overflowReg;
    assign wb.fifoCount_o = fifoCount;

endmodule

// File: tb/tb_intu_writeback_queue.sv
// tb/tb_intu_writeback_queue.sv - directed self-checking bench for intu_writeback_queue
module tb_intu_writeback_queue;
    import intu_writeback_queue_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    intu_writeback_queue_if #(.DEPTH(4)) wbIf();

    intu_writeback_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wbIf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wbIf.intuPacketValid_i = 1'b0;
        wbIf.intuMask_i        = '0;
        wbIf.intuWarp_i        = '0;
        wbIf.intuPacketLanes_i = '0;
    endtask

    task automatic setLane(input int k, input logic [31:0] d, input logic [5:0] dst, input logic we);
        wbIf.intuPacketLanes_i[k*INTU_LANE_W +: INTU_LANE_W] = {d, dst, we, 3'b101};
    endtask

    task automatic push1(input logic [2:0] warp, input logic [31:0] d, input logic [5:0] dst);
        idle();
        wbIf.intuWarp_i        = warp;
        wbIf.intuMask_i        = 32'h0000_0001;
        setLane(0, d, dst, 1'b1);
        wbIf.intuPacketValid_i = 1'b1;
    endtask

    initial begin
        reset          = 1'b1;
        idle();
        wbIf.wbReady_i = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rst valid",   wbIf.wbValid_o, 0);
        chk("rst mask",    wbIf.wbMask_o, 0);
        chk("rst data0",   wbIf.wbData_o[31:0], 0);
        chk("rst warp",    wbIf.wbWarp_o, 0);
        chk("rst dest",    wbIf.wbDestReg_o, 0);
        chk("rst ready",   wbIf.wbReady_o, 1);
        chk("rst count",   wbIf.fifoCount_o, 0);
        chk("rst ovf",     wbIf.overflow_o, 0);
        cyc();
        reset = 1'b1;
        cyc();

        // single push, warp 3, mask 0x5, lane1 active in the write-enables but masked off
        wbIf.intuWarp_i        = 3'd3;
        wbIf.intuMask_i        = 32'h0000_0005;
        setLane(0, 32'h11, 6'd7, 1'b1);
        setLane(1, 32'h99, 6'd7, 1'b1);
        setLane(2, 32'h22, 6'd7, 1'b1);
        wbIf.intuPacketValid_i = 1'b1;
        wbIf.wbReady_i         = 1'b1;
        #1;
`ifdef INTU_WB_BYPASS_EN
        chk("t1 bypass valid", wbIf.wbValid_o, 1);
        chk("t1 bypass mask",  wbIf.wbMask_o, 32'h5);
        chk("t1 bypass lane0", wbIf.wbData_o[31:0], 32'h11);
        cyc();
        idle();
        chk("t1 bypass count", wbIf.fifoCount_o, 0);
        chk("t1 bypass after", wbIf.wbValid_o, 0);
`else
        chk("t1 valid early",  wbIf.wbValid_o, 0);
        cyc();
        idle();
        chk("t1 valid",        wbIf.wbValid_o, 1);
        chk("t1 mask",         wbIf.wbMask_o, 32'h5);
        chk("t1 warp",         wbIf.wbWarp_o, 3);
        chk("t1 dest",         wbIf.wbDestReg_o, 7);
        chk("t1 lane0",        wbIf.wbData_o[31:0], 32'h11);
        chk("t1 lane1",        wbIf.wbData_o[63:32], 0);
        chk("t1 lane2",        wbIf.wbData_o[95:64], 32'h22);
        chk("t1 count",        wbIf.fifoCount_o, 1);
        cyc();
        chk("t1 count drained", wbIf.fifoCount_o, 0);
        chk("t1 valid drained", wbIf.wbValid_o, 0);
        chk("t1 mask drained",  wbIf.wbMask_o, 0);
        chk("t1 dest held",     wbIf.wbDestReg_o, 7);
        chk("t1 lane2 held",    wbIf.wbData_o[95:64], 32'h22);
`endif

        // all lanes valid but no write-enables: silently discarded
        wbIf.wbReady_i         = 1'b0;
        wbIf.intuMask_i        = 32'hFFFF_FFFF;
        for (int k = 0; k < SIZE_CORE; k++) setLane(k, k, 6'd3, 1'b0);
        wbIf.intuPacketValid_i = 1'b1;
        cyc();
        idle();
        chk("t4 zero-we count", wbIf.fifoCount_o, 0);
        chk("t4 zero-we ovf",   wbIf.overflow_o, 0);
        chk("t4 zero-we valid", wbIf.wbValid_o, 0);

        // only lane 31 active: dest taken from lane 31, lane0 masked off
        wbIf.intuWarp_i        = 3'd6;
        wbIf.intuMask_i        = 32'h8000_0000;
        setLane(0,  32'h5,  6'd5,  1'b1);
        setLane(31, 32'h31, 6'd12, 1'b1);
        wbIf.intuPacketValid_i = 1'b1;
        cyc();
        idle();
        chk("t4 lane31 valid", wbIf.wbValid_o, 1);
        chk("t4 lane31 dest",  wbIf.wbDestReg_o, 12);
        chk("t4 lane31 mask",  wbIf.wbMask_o, 32'h8000_0000);
        chk("t4 lane31 data",  wbIf.wbData_o[31*32 +: 32], 32'h31);
        chk("t4 lane0 data",   wbIf.wbData_o[31:0], 0);
        chk("t4 lane31 warp",  wbIf.wbWarp_o, 6);
        wbIf.wbReady_i = 1'b1;
        cyc();
        wbIf.wbReady_i = 1'b0;
        chk("t4 drained", wbIf.fifoCount_o, 0);

        // count==1 with simultaneous push and pop: new entry becomes head
        push1(3'd1, 32'h71, 6'd1);
        cyc();
        push1(3'd2, 32'h72, 6'd2);
        wbIf.wbReady_i = 1'b1;
        cyc();
        idle();
        wbIf.wbReady_i = 1'b0;
        chk("c1 count", wbIf.fifoCount_o, 1);
        chk("c1 warp",  wbIf.wbWarp_o, 2);
        chk("c1 lane0", wbIf.wbData_o[31:0], 32'h72);
        wbIf.wbReady_i = 1'b1;
        cyc();
        wbIf.wbReady_i = 1'b0;
        chk("c1 drained", wbIf.fifoCount_o, 0);

        // full queue with push and pop in the same cycle
        for (int i = 0; i < 4; i++) begin
            push1(i[2:0], 32'hB0 + i, 6'(i + 1));
            cyc();
        end
        idle();
        chk("t3 count full", wbIf.fifoCount_o, 4);
        chk("t3 ready low",  wbIf.wbReady_o, 0);
        push1(3'd7, 32'hCC, 6'd9);
        wbIf.wbReady_i = 1'b1;
        cyc();
        idle();
        chk("t3 count kept", wbIf.fifoCount_o, 4);
        chk("t3 no ovf",     wbIf.overflow_o, 0);
        for (int i = 1; i < 4; i++) begin
            chk("t3 order warp", wbIf.wbWarp_o, i);
            chk("t3 order data", wbIf.wbData_o[31:0], 32'hB0 + i);
            cyc();
        end
        chk("t3 4th warp", wbIf.wbWarp_o, 7);
        chk("t3 4th data", wbIf.wbData_o[31:0], 32'hCC);
        cyc();
        chk("t3 drained", wbIf.fifoCount_o, 0);

        // fill, overflow on a 5th push, then drain in order
        wbIf.wbReady_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push1(i[2:0], 32'hA0 + i, 6'(i + 1));
            cyc();
        end
        idle();
        chk("t2 count full", wbIf.fifoCount_o, 4);
        chk("t2 ready low",  wbIf.wbReady_o, 0);
        chk("t2 ovf before", wbIf.overflow_o, 0);
        push1(3'd5, 32'hEE, 6'd9);
        cyc();
        idle();
        chk("t2 ovf set",    wbIf.overflow_o, 1);
        chk("t2 count kept", wbIf.fifoCount_o, 4);
        wbIf.wbReady_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2 drain warp", wbIf.wbWarp_o, i);
            chk("t2 drain data", wbIf.wbData_o[31:0], 32'hA0 + i);
            chk("t2 drain dest", wbIf.wbDestReg_o, i + 1);
            cyc();
        end
        chk("t2 drained",    wbIf.fifoCount_o, 0);
        chk("t2 valid low",  wbIf.wbValid_o, 0);
        chk("t2 ovf sticky", wbIf.overflow_o, 1);

        // reset mid-operation with two entries held
        wbIf.wbReady_i = 1'b0;
        push1(3'd1, 32'h61, 6'd1);
        cyc();
        push1(3'd2, 32'h62, 6'd2);
        cyc();
        idle();
        chk("t5 count before", wbIf.fifoCount_o, 2);
        #2 reset = 1'b0;
        #1;
        chk("t5 valid",  wbIf.wbValid_o, 0);
        chk("t5 count",  wbIf.fifoCount_o, 0);
        chk("t5 ovf",    wbIf.overflow_o, 0);
        chk("t5 mask",   wbIf.wbMask_o, 0);
        chk("t5 ready",  wbIf.wbReady_o, 1);
        reset = 1'b1;
        cyc();
        push1(3'd4, 32'h44, 6'd3);
        cyc();
        idle();
        chk("t5 post valid", wbIf.wbValid_o, 1);
        chk("t5 post warp",  wbIf.wbWarp_o, 4);
        chk("t5 post data",  wbIf.wbData_o[31:0], 32'h44);
        chk("t5 post dest",  wbIf.wbDestReg_o, 3);
        chk("t5 post count", wbIf.fifoCount_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
